// File: rtl/gf_mul_pkg.sv
// Shared types and helpers for the digit-serial GF(2^M) multiplier.
package gf_mul_pkg;

    // Number of digit steps needed to consume an m-bit operand d bits at a time.
    function automatic int unsigned ndig(input int unsigned m, input int unsigned d);
        return (m + d - 1) / d;
    endfunction

    // x^163 + x^7 + x^6 + x^3 + 1 with the x^163 term dropped.
    localparam logic [162:0] GF163_POLY = 163'hC9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gf_digit_step.sv
// One MSB-first digit of a polynomial-basis multiply: D shift-reduce-add cells.
module gf_digit_step #(
    parameter int unsigned M = 163,
    parameter int unsigned D = 4
) (
    input  logic [M-1:0] acc,
    input  logic [M-1:0] a,
    input  logic [M-1:0] g,
    input  logic [D-1:0] digit,
    output logic [M-1:0] acc_next_c
);

    logic [M-1:0] t;

    always_comb begin
        t = acc;
        for (int i = int'(D) - 1; i >= 0; i--) begin
            t = (t << 1) ^ (t[M-1] ? g : '0) ^ (digit[i] ? a : '0);
        end
        acc_next_c = t;
    end

endmodule

// File: rtl/gf_digit_serial_mul_seq.sv
// Sequential digit-serial GF(2^M) multiplier with start/done handshake.
// Consumes b MSB-digit first, one digit per clock; result = a*b mod f.
module gf_digit_serial_mul_seq
    import gf_mul_pkg::*;
#(
    parameter int unsigned M = 163,
    parameter int unsigned D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic [M-1:0] g,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result
);

    localparam int unsigned NDIG = ndig(M, D);
    localparam int unsigned NB   = NDIG * D;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_t          state;
    logic [M-1:0]    a_q;
    logic [M-1:0]    g_q;
    logic [NB-1:0]   b_q;
    logic [M-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   dig_idx_c;
    logic [D-1:0]    digit_c;
    logic [M-1:0]    acc_next_c;

    // Digits are taken from the top of the padded multiplier downwards.
    always_comb begin
        dig_idx_c = CW'(NDIG - 1) - cnt;
        digit_c   = b_q[int'(dig_idx_c) * D +: D];
    end

    gf_digit_step #(
        .M(M),
        .D(D)
    ) u_step (
        .acc        (acc),
        .a          (a_q),
        .g          (g_q),
        .digit      (digit_c),
        .acc_next_c (acc_next_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        g_q   <= g;
                        b_q   <= NB'(b);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NDIG - 1)) begin
                        result <= acc_next_c;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_digit_serial_mul_seq.sv
// Bench for gf_digit_serial_mul_seq: four digit sizes against a product-and-reduce model.
module tb_gf_digit_serial_mul_seq;
    import gf_mul_pkg::*;

    localparam int unsigned M = 163;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] a, b, g;
    logic [3:0]   busy_v, done_v;
    logic [M-1:0] res0, res1, res2, res3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gf_digit_serial_mul_seq #(.M(M), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .g(g),
        .busy(busy_v[0]), .done(done_v[0]), .result(res0));
    gf_digit_serial_mul_seq #(.M(M), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .g(g),
        .busy(busy_v[1]), .done(done_v[1]), .result(res1));
    gf_digit_serial_mul_seq #(.M(M), .D(7)) u_d7 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .g(g),
        .busy(busy_v[2]), .done(done_v[2]), .result(res2));
    gf_digit_serial_mul_seq #(.M(M), .D(163)) u_d163 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .g(g),
        .busy(busy_v[3]), .done(done_v[3]), .result(res3));

    function automatic int nd_of(input int i);
        case (i)
            0: return 41;
            1: return 163;
            2: return 24;
            default: return 1;
        endcase
    endfunction

    function automatic logic [M-1:0] res_of(input int i);
        case (i)
            0: return res0;
            1: return res1;
            2: return res2;
            default: return res3;
        endcase
    endfunction

    // Carry-less product to 2M bits, then long division by f = x^M + g.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y,
                                            input logic [M-1:0] f);
        logic [2*M-1:0] p;
        logic [2*M-1:0] fx;
        p  = '0;
        fx = {{(M-1){1'b0}}, 1'b1, f};
        for (int i = 0; i < int'(M); i++)
            if (y[i]) p ^= {{M{1'b0}}, x} << i;
        for (int k = 2*int'(M) - 2; k >= int'(M); k--)
            if (p[k]) p ^= fx << (k - int'(M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand_m();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: each unit is idle or counting down to a known product.
    logic [3:0]   m_busy, m_done;
    logic [M-1:0] m_res  [4];
    logic [M-1:0] m_pend [4];
    int           m_left [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
                m_pend[i] <= '0;
                m_left[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_res[i]  <= m_pend[i];
                    end
                end else if (start) begin
                    m_busy[i] <= 1'b1;
                    m_left[i] <= nd_of(i);
                    m_pend[i] <= gf_mul(a, b, g);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy[%0d]", i), M'(busy_v[i]), M'(m_busy[i]));
                chk($sformatf("done[%0d]", i), M'(done_v[i]), M'(m_done[i]));
                chk($sformatf("result[%0d]", i), res_of(i), m_res[i]);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != 4'b0 || done_v != 4'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("wait_idle_timeout", M'(busy_v), '0);
    endtask

    task automatic mul_once(input logic [M-1:0] x, input logic [M-1:0] y,
                            output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy_v[0] ? 1 : 0;
        while (!done_v[0] && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (busy_v[0]) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, ndone, cyc, last, nper;
        int cnt_done [4];
        logic [M-1:0] x1, y1, exp1, got;

        rst = 1'b0; start = 1'b0; a = '0; b = '0; g = GF163_POLY;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("reset_busy", M'(busy_v), '0);
        chk("reset_done", M'(done_v), '0);
        chk("reset_result", res0 | res1 | res2 | res3, '0);

        // 1*1 = 1, latency and busy width for D=4
        mul_once(M'(1), M'(1), lat, bcnt);
        chk("t1_latency", M'(lat), M'(41));
        chk("t1_busy_cycles", M'(bcnt), M'(41));
        chk("t1_result", res0, M'(1));
        @(negedge clk);
        chk("t1_done_drops", M'(done_v[0]), '0);
        chk("t1_result_held", res0, M'(1));
        wait_idle();

        // x^162 * x wraps through the reduction polynomial
        mul_once(M'(1) << 162, M'(2), lat, bcnt);
        chk("t2_result_d4", res0, 163'hC9);
        wait_idle();
        chk("t2_result_d1", res1, 163'hC9);
        chk("t2_result_d7", res2, 163'hC9);
        chk("t2_result_d163", res3, 163'hC9);

        // Start pulsed mid-multiply is ignored
        x1 = rand_m(); y1 = rand_m(); exp1 = gf_mul(x1, y1, g);
        @(negedge clk);
        a = x1; b = y1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = rand_m(); b = rand_m(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; got = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                got = res0;
            end
        end
        chk("t4_done_count", M'(ndone), M'(1));
        chk("t4_result", got, exp1);
        wait_idle();

        // Reset in the middle of a multiply
        @(negedge clk);
        a = rand_m(); b = rand_m(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", M'(busy_v), '0);
        chk("t5_done", M'(done_v), '0);
        chk("t5_result", res0 | res1 | res2 | res3, '0);
        @(negedge clk);
        rst = 1'b0;
        x1 = rand_m(); y1 = rand_m();
        mul_once(x1, y1, lat, bcnt);
        chk("t5_fresh_latency", M'(lat), M'(41));
        chk("t5_fresh_result", res0, gf_mul(x1, y1, g));
        wait_idle();

        // Start held high: D=4 completes every 42 cycles
        start = 1'b1;
        last = -1; nper = 0;
        for (cyc = 0; cyc < 220; cyc++) begin
            a = rand_m(); b = rand_m();
            @(negedge clk);
            if (done_v[0]) begin
                if (last >= 0) begin
                    chk("t6_period", M'(cyc - last), M'(42));
                    nper++;
                end
                last = cyc;
            end
        end
        start = 1'b0;
        chk("t6_periods_seen", M'(nper >= 4), M'(1));
        wait_idle();

        // Random operands, random start density, fixed then random g
        for (int i = 0; i < 4; i++) cnt_done[i] = 0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            start = ($urandom_range(0, 3) != 0);
            a = rand_m();
            b = rand_m();
            g = (cyc < 10000) ? GF163_POLY : rand_m();
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_v[i]) cnt_done[i]++;
        end
        start = 1'b0;
        g = GF163_POLY;
        chk("t3_d4_completions", M'(cnt_done[0] > 300), M'(1));
        chk("t3_d1_completions", M'(cnt_done[1] > 80), M'(1));
        chk("t3_d7_completions", M'(cnt_done[2] > 500), M'(1));
        chk("t3_d163_completions", M'(cnt_done[3] > 5000), M'(1));
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
